am2914: RTL and testbench

- Sequential priority interrupt controller that sequences the 8-input priority encoder datapath. Edge-latches 8 active-low requests, applies a mask and the current service level, and raises an active-low interrupt.
- On acknowledge it delivers the winning vector, clears that request and nests the service level on a small status stack.
- Configured by the microprogram through a 4-bit instruction port, in the style of the Am29xx bitslice family.

---
 rtl/am2914.sv | 169 ++++++++++++++++
 tb/tb_am2914.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/am2914.sv
// am2914: sequential priority interrupt controller for an 8-input priority encoder datapath.
// Latency: a falling edge on p_ is latched at the next clock; irq_ goes low combinationally from that state.
// Handshake: ack_ is a one-cycle strobe and only takes effect while irq_ is low. Optional macro AM2914_VBASE_EN adds the vector base register.
module am2914 #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] p_,
  input  logic [3:0] i,
  input  logic       ie_,
  input  logic [7:0] d,
  input  logic       ack_,
  input  logic       oe_,
  output logic       irq_,
  output logic [7:0] v,
  output logic [3:0] stat,
  output logic [7:0] mask,
  output logic       ovf,
  output logic       unf
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    r_lat, r_mask, r_pprev;
  logic          r_sv, r_ien, r_ovf, r_unf;
  logic [2:0]    r_slv, r_vec;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_stk [DEPTH];

  logic [7:0]    w_lat_n, w_mask_n, w_pend;
  logic          w_sv_n, w_ien_n, w_ovf_n, w_unf_n, w_irq_n, w_ack, w_clr;
  logic [2:0]    w_slv_n, w_vec_n, w_top;
  logic [CW-1:0] w_cnt_n, w_cm1;
  logic [2:0]    w_stk_n [DEPTH];
  logic          w_unused_cm1;

`ifdef AM2914_VBASE_EN
  logic [4:0]    r_base, w_base_n;
`endif

  // Highest-priority pending request; irq_ only for a level above the one in service.
  always_comb begin
    w_pend = r_lat & ~r_mask;
    w_top  = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (w_pend[k]) w_top = 3'(k);
    end
    w_irq_n = ~(r_ien && (w_pend != 8'h00) && (!r_sv || (w_top > r_slv)));
  end

  assign irq_ = w_irq_n;
  assign w_ack = ~ack_ & ~w_irq_n;
  assign w_clr = rst | (~ie_ & (i == 4'h1));

  // Next state: acknowledge first, then the instruction, then new request edges win.
  always_comb begin
    w_lat_n  = r_lat;
    w_mask_n = r_mask;
    w_sv_n   = r_sv;
    w_slv_n  = r_slv;
    w_ien_n  = r_ien;
    w_vec_n  = r_vec;
    w_cnt_n  = r_cnt;
    w_stk_n  = r_stk;
    w_ovf_n  = r_ovf;
    w_unf_n  = r_unf;
    w_cm1    = '0;
`ifdef AM2914_VBASE_EN
    w_base_n = r_base;
`endif
    if (w_ack) begin
      w_vec_n        = w_top;
      w_lat_n[w_top] = 1'b0;
      if (r_sv) begin
        if (r_cnt == CW'(DEPTH)) begin
          w_ovf_n = 1'b1;
        end else begin
          w_stk_n[r_cnt[IW-1:0]] = r_slv;
          w_cnt_n                = r_cnt + 1'b1;
        end
      end
      w_slv_n = w_top;
      w_sv_n  = 1'b1;
    end
    if (!ie_) begin
      case (i)
        4'h2: w_lat_n = 8'h00;
        4'h3: w_lat_n[d[2:0]] = 1'b0;
        4'h4: w_mask_n = d;
        4'h5: w_mask_n = r_mask | d;
        4'h6: w_mask_n = r_mask & ~d;
        4'h7: w_ien_n = 1'b1;
        4'h8: w_ien_n = 1'b0;
        4'h9: begin
          if (w_cnt_n != '0) begin
            w_cm1   = w_cnt_n - 1'b1;
            w_slv_n = w_stk_n[w_cm1[IW-1:0]];
            w_sv_n  = 1'b1;
            w_cnt_n = w_cm1;
          end else begin
            if (!w_sv_n) w_unf_n = 1'b1;
            w_sv_n  = 1'b0;
            w_slv_n = 3'd0;
          end
        end
        4'hA: {w_sv_n, w_slv_n} = d[3:0];
`ifdef AM2914_VBASE_EN
        4'hB: w_base_n = d[7:3];
`endif
        4'hC: begin
          w_ovf_n = 1'b0;
          w_unf_n = 1'b0;
        end
        default: ;
      endcase
    end
    w_lat_n = w_lat_n | (r_pprev & ~p_);
  end

  assign w_unused_cm1 = ^w_cm1;

  // State register; reset and master clear both return everything to idle.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_lat   <= 8'h00;
      r_mask  <= 8'hFF;
      r_pprev <= 8'hFF;
      r_sv    <= 1'b0;
      r_slv   <= 3'd0;
      r_ien   <= 1'b0;
      r_vec   <= 3'd0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      for (int k = 0; k < DEPTH; k++) r_stk[k] <= 3'd0;
    end else begin
      r_lat   <= w_lat_n;
      r_mask  <= w_mask_n;
      r_pprev <= p_;
      r_sv    <= w_sv_n;
      r_slv   <= w_slv_n;
      r_ien   <= w_ien_n;
      r_vec   <= w_vec_n;
      r_cnt   <= w_cnt_n;
      r_ovf   <= w_ovf_n;
      r_unf   <= w_unf_n;
      r_stk   <= w_stk_n;
    end
  end

`ifdef AM2914_VBASE_EN
  // Vector base register, loaded by instruction B.
  always_ff @(posedge clk) begin
    if (w_clr) r_base <= 5'd0;
    else       r_base <= w_base_n;
  end
  assign v = oe_ ? 8'hZZ : {r_base, r_vec};
`else
  assign v = oe_ ? 8'hZZ : {5'b00000, r_vec};
`endif

  assign stat = {r_sv, r_slv};
  assign mask = r_mask;
  assign ovf  = r_ovf;
  assign unf  = r_unf;

endmodule

// File: tb/tb_am2914.sv
module tb_am2914;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] p_  = 8'hFF;
  logic [3:0] i   = 4'h0;
  logic       ie_ = 1'b1;
  logic [7:0] d   = 8'h00;
  logic       ack_ = 1'b1;
  logic       oe_ = 1'b0;
  logic       irq_;
  logic [7:0] v;
  logic [3:0] stat;
  logic [7:0] mask;
  logic       ovf, unf;

  int checks = 0;
  int failures = 0;

  am2914 #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .p_(p_), .i(i), .ie_(ie_), .d(d), .ack_(ack_), .oe_(oe_),
    .irq_(irq_), .v(v), .stat(stat), .mask(mask), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic instr(input logic [3:0] code, input logic [7:0] data);
    ie_ = 1'b0; i = code; d = data;
    tick();
    ie_ = 1'b1; i = 4'h0; d = 8'h00;
  endtask

  task automatic pulse(input int k);
    p_[k] = 1'b0;
    tick();
    p_[k] = 1'b1;
  endtask

  task automatic ack();
    ack_ = 1'b0;
    tick();
    ack_ = 1'b1;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_irq", {7'd0, irq_}, 8'h01);
    chk("rst_v", v, 8'h00);
    chk("rst_stat", {4'd0, stat}, 8'h00);
    chk("rst_mask", mask, 8'hFF);
    chk("rst_ovf", {7'd0, ovf}, 8'h00);
    chk("rst_unf", {7'd0, unf}, 8'h00);

    // Single request at level 5
    instr(4'h4, 8'h00);
    chk("mask_load", mask, 8'h00);
    instr(4'h7, 8'h00);
    chk("idle_irq", {7'd0, irq_}, 8'h01);
    pulse(5);
    chk("p5_irq", {7'd0, irq_}, 8'h00);
    ack();
    chk("ack5_v", v, 8'h05);
    chk("ack5_stat", {4'd0, stat}, 8'h0D);
    chk("ack5_irq", {7'd0, irq_}, 8'h01);

    // Nesting over level 5
    pulse(3);
    chk("p3_below", {7'd0, irq_}, 8'h01);
    pulse(7);
    chk("p7_above", {7'd0, irq_}, 8'h00);
    ack();
    chk("ack7_v", v, 8'h07);
    chk("ack7_stat", {4'd0, stat}, 8'h0F);
    instr(4'h9, 8'h00);
    chk("ret_to5", {4'd0, stat}, 8'h0D);
    chk("ret5_irq", {7'd0, irq_}, 8'h01);
    instr(4'h9, 8'h00);
    chk("ret_empty", {4'd0, stat}, 8'h00);
    chk("p3_now", {7'd0, irq_}, 8'h00);
    ack();
    chk("ack3_v", v, 8'h03);
    chk("ack3_stat", {4'd0, stat}, 8'h0B);
    instr(4'h9, 8'h00);
    instr(4'h2, 8'h00);

    // Simultaneous held requests 2 and 6
    p_ = 8'b1011_1011;
    tick();
    chk("p26_irq", {7'd0, irq_}, 8'h00);
    ack();
    chk("ack6_v", v, 8'h06);
    chk("ack6_stat", {4'd0, stat}, 8'h0E);
    instr(4'h9, 8'h00);
    chk("ret6_stat", {4'd0, stat}, 8'h00);
    chk("p2_pend", {7'd0, irq_}, 8'h00);
    ack();
    chk("ack2_v", v, 8'h02);
    tick(); tick();
    instr(4'h9, 8'h00);
    chk("held_nolatch", {7'd0, irq_}, 8'h01);
    p_ = 8'hFF;
    tick();

    // Six nested levels 2..7 against a 4-deep stack
    for (int k = 2; k <= 7; k++) begin
      pulse(k);
      if (k == 7) chk("pre6_ovf", {7'd0, ovf}, 8'h00);
      ack();
    end
    chk("nest_ovf", {7'd0, ovf}, 8'h01);
    chk("nest_stat", {4'd0, stat}, 8'h0F);
    instr(4'h9, 8'h00);
    chk("pop1", {4'd0, stat}, 8'h0D);
    instr(4'h9, 8'h00);
    instr(4'h9, 8'h00);
    instr(4'h9, 8'h00);
    chk("pop4", {4'd0, stat}, 8'h0A);
    instr(4'h9, 8'h00);
    chk("pop5_stat", {4'd0, stat}, 8'h00);
    chk("pop5_unf", {7'd0, unf}, 8'h00);
    instr(4'h9, 8'h00);
    chk("pop6_unf", {7'd0, unf}, 8'h01);
    instr(4'h9, 8'h00);
    instr(4'hC, 8'h00);
    chk("clr_ovf", {7'd0, ovf}, 8'h00);
    chk("clr_unf", {7'd0, unf}, 8'h00);

    // Mask, unmask, and edge-vs-clear race
    instr(4'h4, 8'hFF);
    pulse(4);
    chk("masked_irq", {7'd0, irq_}, 8'h01);
    instr(4'h6, 8'h10);
    chk("unmask4", mask, 8'hEF);
    chk("unmask4_irq", {7'd0, irq_}, 8'h00);
    p_[1] = 1'b0; ie_ = 1'b0; i = 4'h3; d = 8'h01;
    tick();
    p_[1] = 1'b1; ie_ = 1'b1; i = 4'h0; d = 8'h00;
    instr(4'h5, 8'h01);
    chk("mask_or", mask, 8'hEF);
    instr(4'h4, 8'h00);
    ack();
    chk("ack4_v", v, 8'h04);
    instr(4'h9, 8'h00);
    chk("lat1_kept", {7'd0, irq_}, 8'h00);
    ack();
    chk("ack1_v", v, 8'h01);
    instr(4'h9, 8'h00);
    pulse(0);
    chk("p0_irq", {7'd0, irq_}, 8'h00);
    instr(4'h3, 8'h00);
    chk("clr0_irq", {7'd0, irq_}, 8'h01);

    // Ack and return in the same cycle
    pulse(5);
    ack();
    pulse(6);
    ack_ = 1'b0; ie_ = 1'b0; i = 4'h9;
    tick();
    ack_ = 1'b1; ie_ = 1'b1; i = 4'h0;
    chk("ackret_v", v, 8'h06);
    chk("ackret_stat", {4'd0, stat}, 8'h0D);
    instr(4'h9, 8'h00);
    chk("ackret_depth", {4'd0, stat}, 8'h00);

    // Vector base load, then reset mid-service
    instr(4'hA, 8'h05);
    chk("status_load", {4'd0, stat}, 8'h05);
    instr(4'hA, 8'h00);
    instr(4'hB, 8'hA8);
    pulse(3);
    ack();
`ifdef AM2914_VBASE_EN
    chk("base_v", v, 8'hAB);
`else
    chk("base_v", v, 8'h03);
`endif
    pulse(6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_stat", {4'd0, stat}, 8'h00);
    chk("mrst_mask", mask, 8'hFF);
    chk("mrst_irq", {7'd0, irq_}, 8'h01);
    chk("mrst_v", v, 8'h00);

    // Master clear instruction and ack while no interrupt
    instr(4'h4, 8'h00);
    instr(4'h7, 8'h00);
    pulse(6);
    chk("mc_pre_irq", {7'd0, irq_}, 8'h00);
    instr(4'h1, 8'h00);
    chk("mc_irq", {7'd0, irq_}, 8'h01);
    chk("mc_mask", mask, 8'hFF);
    ack();
    chk("noirq_ack_v", v, 8'h00);
    chk("noirq_ack_stat", {4'd0, stat}, 8'h00);
    instr(4'h4, 8'h00);
    instr(4'h8, 8'h00);
    pulse(2);
    chk("ien_off_irq", {7'd0, irq_}, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
